// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: shared state encoding, BCD limit and load sanitiser for the stopwatch
package stopwatch_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PAUSED = 2'd2, LAP = 2'd3} state_t;
  localparam logic [3:0] BCD_MAX = 4'd9;
  function automatic logic [3:0] bcd_clamp(input logic [3:0] v);
    return (v > BCD_MAX) ? BCD_MAX : v;
  endfunction
endpackage

// File: rtl/bcd_digit.sv
// bcd_digit: one up/down BCD digit with clear, load and step
// ports: clk, BTNU (sync reset), clr, ld/ld_val, step, dir in; q digit and term (at 9 up / 0 down) out
module bcd_digit
  import stopwatch_pkg::*;
(
  input  logic       clk,
  input  logic       BTNU,
  input  logic       clr,
  input  logic       ld,
  input  logic [3:0] ld_val,
  input  logic       step,
  input  logic       dir,
  output logic [3:0] q,
  output logic       term
);
  logic [3:0] q_q, q_d;
  always_comb q_d = dir ? ((q_q == 4'd0) ? BCD_MAX : q_q - 4'd1)
                        : ((q_q == BCD_MAX) ? 4'd0 : q_q + 4'd1);
  always_ff @(posedge clk) begin
    if (BTNU || clr) q_q <= 4'd0;
    else if (ld) q_q <= ld_val;
    else if (step) q_q <= q_d;
  end
  assign q    = q_q;
  assign term = dir ? (q_q == 4'd0) : (q_q == BCD_MAX);
endmodule

// File: rtl/bcd_stopwatch_core.sv
// bcd_stopwatch_core: N-digit BCD stopwatch with up/down count, pause, lap hold and preload
// ports: clk, BTNU (sync reset), en, start_stop/lap/load pulses, dir, load_val in;
//        count, display, carry, running, state out
module bcd_stopwatch_core
  import stopwatch_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int TICK_DIV = 100000,
  parameter int WRAP     = 1
) (
  input  logic              clk,
  input  logic              BTNU,
  input  logic              en,
  input  logic              start_stop,
  input  logic              lap,
  input  logic              dir,
  input  logic              load,
  input  logic [4*DIGITS-1:0] load_val,
  output logic [4*DIGITS-1:0] count,
  output logic [4*DIGITS-1:0] display,
  output logic              carry,
  output logic              running,
  output logic [1:0]        state
);
  localparam int W  = 4 * DIGITS;
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam bit WRAP_EN = (WRAP != 0);
  state_t          state_q;
  logic [PW-1:0]   presc_q;
  logic [W-1:0]    lap_q, count_w;
  logic            carry_q;
  logic [DIGITS-1:0] term;
  logic [DIGITS:0]   chain;
  logic active, tick, leave, ld_ok, all_term, sat, adv;
  assign active   = (state_q == RUN) || (state_q == LAP);
  assign tick     = active && (presc_q == PW'(TICK_DIV - 1));
  assign leave    = start_stop && active;
  assign ld_ok    = load && !active;
  assign all_term = &term;
  // saturating build stops on the terminal value instead of stepping into the wrap
  assign sat      = tick && all_term && !WRAP_EN;
  // a start_stop that leaves RUN/LAP swallows the coinciding tick
  assign adv      = tick && !leave && !sat;
  assign chain[0] = adv;
  genvar g;
  generate
    for (g = 0; g < DIGITS; g++) begin : g_dig
      assign chain[g+1] = chain[g] && term[g];
      bcd_digit u_dig (
        .clk    (clk),
        .BTNU   (BTNU),
        .clr    (!en),
        .ld     (ld_ok),
        .ld_val (bcd_clamp(load_val[4*g +: 4])),
        .step   (chain[g]),
        .dir    (dir),
        .q      (count_w[4*g +: 4]),
        .term   (term[g])
      );
    end
  endgenerate
  always_ff @(posedge clk) begin
    if (BTNU || !en) begin
      state_q <= IDLE;
      presc_q <= '0;
      lap_q   <= '0;
      carry_q <= 1'b0;
    end else if (ld_ok) begin
      carry_q <= 1'b0;
    end else if (leave) begin
      state_q <= PAUSED;
      carry_q <= 1'b0;
    end else begin
      carry_q <= adv && all_term;
      presc_q <= start_stop ? '0 : (active ? (tick ? '0 : presc_q + PW'(1)) : presc_q);
      if (start_stop) state_q <= RUN;
      else if (sat) state_q <= PAUSED;
      else if (lap && state_q == RUN) begin
        state_q <= LAP;
        lap_q   <= count_w;
      end else if (lap && state_q == LAP) state_q <= RUN;
    end
  end
  assign count   = count_w;
  assign display = (state_q == LAP) ? lap_q : count_w;
  assign carry   = carry_q;
  assign running = active;
  assign state   = state_q;
endmodule
